// File: rtl/ldm_stm_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer_pkg
// Shared definitions for the LDM/STM block-transfer sequencer:
//   - state_t      : sequencer FSM states
//   - MODE_*       : addressing modes encoded as {up, pre}
//   - WORD_BYTES   : byte stride between consecutive transferred words
// ---------------------------------------------------------------------------
package ldm_stm_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_XFER  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Addressing modes as {up, pre}
    localparam logic [1:0] MODE_DA = 2'b00;
    localparam logic [1:0] MODE_DB = 2'b01;
    localparam logic [1:0] MODE_IA = 2'b10;
    localparam logic [1:0] MODE_IB = 2'b11;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/ldm_stm_sequencer_prio_enc16.sv
// ---------------------------------------------------------------------------
// prio_enc16
// Combinational lowest-set-bit finder for a 16-bit vector.
// Ports:
//   i_vec   in  16  vector to search
//   o_idx   out 4   index of the lowest set bit (0 when i_vec is zero)
//   o_valid out 1   high when any bit of i_vec is set
// ---------------------------------------------------------------------------
module prio_enc16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx,
    output logic        o_valid
);

    always_comb begin
        o_idx   = '0;
        o_valid = |i_vec;
        // Scan from the top down so the lowest set bit is the last to win.
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// ---------------------------------------------------------------------------
// ldm_stm_sequencer
// Multi-cycle LDM/STM block-transfer controller. Walks the register list
// lowest-first, generates word addresses for IA/IB/DA/DB and handshakes each
// word with memory. Loads pulse one active-low register write enable per word.
// Ports:
//   i_clk, i_clr            clock (rising edge), asynchronous active-high reset
//   i_start                 one-cycle request, honoured only in IDLE
//   i_is_load, i_up, i_pre  decoded instruction: LDM/STM, direction, before/after
//   i_base_addr, i_reg_list base register value and register list
//   i_mem_ack               memory completion for the current word
//   o_mem_req, o_mem_rw     memory request and direction (1 = read)
//   o_mem_addr              current word address
//   o_reg_sel               index of the register being transferred
//   o_rf_en_n               active-low one-hot register write enables
//   o_busy, o_done          not-IDLE flag and one-cycle completion pulse
//   o_wb_addr               final base value, valid while o_done is high
// ---------------------------------------------------------------------------
module ldm_stm_sequencer
    import ldm_stm_sequencer_pkg::*;
#(
    parameter int NREGS = 16,   // prio_enc16 fixes this at 16
    parameter int AW    = 32
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic             i_is_load,
    input  logic             i_up,
    input  logic             i_pre,
    input  logic [AW-1:0]    i_base_addr,
    input  logic [NREGS-1:0] i_reg_list,
    input  logic             i_mem_ack,
    output logic             o_mem_req,
    output logic             o_mem_rw,
    output logic [AW-1:0]    o_mem_addr,
    output logic [3:0]       o_reg_sel,
    output logic [NREGS-1:0] o_rf_en_n,
    output logic             o_busy,
    output logic             o_done,
    output logic [AW-1:0]    o_wb_addr
);

    localparam int CW = $clog2(NREGS + 1);

    state_t           r_state;
    state_t           w_state_next;
    logic             r_is_load;
    logic             r_up;
    logic             r_pre;
    logic [AW-1:0]    r_base;
    logic [NREGS-1:0] r_list;      // registers still to transfer
    logic [AW-1:0]    r_addr;
    logic [AW-1:0]    r_wb;

    logic [3:0]       w_sel;
    logic             w_sel_valid;
    logic [NREGS-1:0] w_onehot;
    logic [NREGS-1:0] w_list_after;
    logic [CW-1:0]    w_cnt;
    logic [AW-1:0]    w_four_n;
    logic [AW-1:0]    w_start_addr;
    logic [AW-1:0]    w_wb_addr;

    prio_enc16 u_prio (
        .i_vec   (r_list),
        .o_idx   (w_sel),
        .o_valid (w_sel_valid)
    );

    assign w_onehot     = NREGS'(1) << w_sel;
    assign w_list_after = r_list & ~w_onehot;

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NREGS; i++) begin
            w_cnt = w_cnt + CW'(r_list[i]);
        end
    end

    assign w_four_n = AW'({w_cnt, 2'b00});

    // Lowest register always sits at the lowest address, so decrementing
    // modes start below the base and walk upward like the incrementing ones.
    always_comb begin
        w_start_addr = r_base;
        case ({r_up, r_pre})
            MODE_IA: w_start_addr = r_base;
            MODE_IB: w_start_addr = r_base + AW'(WORD_BYTES);
            MODE_DA: w_start_addr = r_base - w_four_n + AW'(WORD_BYTES);
            MODE_DB: w_start_addr = r_base - w_four_n;
            default: w_start_addr = r_base;
        endcase
    end

    assign w_wb_addr = r_up ? (r_base + w_four_n) : (r_base - w_four_n);

    always_comb begin
        w_state_next = r_state;
        o_mem_req    = 1'b0;
        o_done       = 1'b0;
        o_rf_en_n    = '1;
        case (r_state)
            ST_IDLE: begin
                if (i_start) w_state_next = ST_SETUP;
            end
            ST_SETUP: begin
                w_state_next = (w_cnt == '0) ? ST_DONE : ST_XFER;
            end
            ST_XFER: begin
                o_mem_req = 1'b1;
                if (i_mem_ack) begin
                    if (r_is_load && w_sel_valid) o_rf_en_n = ~w_onehot;
                    if (w_list_after == '0) w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state   <= ST_IDLE;
            r_is_load <= 1'b0;
            r_up      <= 1'b0;
            r_pre     <= 1'b0;
            r_base    <= '0;
            r_list    <= '0;
            r_addr    <= '0;
            r_wb      <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_is_load <= i_is_load;
                        r_up      <= i_up;
                        r_pre     <= i_pre;
                        r_base    <= i_base_addr;
                        r_list    <= i_reg_list;
                    end
                end
                ST_SETUP: begin
                    r_addr <= w_start_addr;
                    r_wb   <= w_wb_addr;
                end
                ST_XFER: begin
                    if (i_mem_ack) begin
                        r_list <= w_list_after;
                        r_addr <= r_addr + AW'(WORD_BYTES);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_rw   = r_is_load;
    assign o_mem_addr = r_addr;
    assign o_reg_sel  = w_sel;
    assign o_busy     = (r_state != ST_IDLE);
    assign o_wb_addr  = r_wb;

endmodule

// File: doc/ldm_stm_sequencer.md
Name: ldm_stm_sequencer

Overview:
- Multi-cycle controller that sequences block transfers (LDM/STM) between the 16-entry register file and data memory.
- Walks a 16-bit register list lowest-first, generates word addresses for all four addressing modes (IA/IB/DA/DB), and handshakes each word with memory.
- For loads, drives the register file's per-register active-low write enables, one register per transfer.
- Sits beside the control unit; the control unit hands it a decoded instruction and waits for done.

Parameters:
- NREGS, 16, number of architectural registers (width of the list and enable vector).
- AW, 32, address width.

Ports:
- CLK  in  1  system clock, rising edge.
- CLR  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request to begin a transfer; honoured only in IDLE.
- is_load  in  1  1 = LDM (memory to registers), 0 = STM.
- up  in  1  1 = increment (IA/IB), 0 = decrement (DA/DB).
- pre  in  1  1 = before (IB/DB), 0 = after (IA/DA).
- base_addr  in  AW  base register value.
- reg_list  in  NREGS  register list; bit i selects Ri.
- mem_ack  in  1  memory completion for the current word (MOC).
- mem_req  out  1  memory access request.
- mem_rw  out  1  1 = read, 0 = write; equals the latched is_load.
- mem_addr  out  AW  current word address.
- reg_sel  out  4  index of the register being transferred (STM read mux / LDM target).
- rf_en_n  out  NREGS  active-low one-hot register write enables.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- wb_addr  out  AW  final base value for optional writeback; valid when done is high.

Behaviour:
- Reset (CLR high, asynchronous, any state): go to IDLE.
  - mem_req, busy and done = 0; rf_en_n = all 1s.
  - mem_addr, wb_addr, reg_sel = 0; mem_rw = 0.
- Capture: start in IDLE latches is_load, up, pre, base_addr and reg_list. start while busy is ignored.
- States:
  - IDLE -> SETUP on start.
  - SETUP (1 cycle): n = popcount(list), range 0..16, held 5 bits wide.
    - Start address:
      - IA: base.
      - IB: base+4.
      - DA: base-4n+4.
      - DB: base-4n.
    - Writeback: up ? base+4n : base-4n.
    - All arithmetic is modulo 2^AW.
    - n = 0 -> DONE, with no memory access and wb_addr = base. Otherwise -> XFER.
  - XFER: mem_req = 1; reg_sel = index of the lowest set bit of the remaining list; mem_addr = current address.
    - Hold all outputs stable until mem_ack; the wait is unbounded.
    - On a mem_ack cycle:
      - If a load, rf_en_n[reg_sel] = 0 for that cycle only; memory data is captured at that edge.
      - Clear that bit from the remaining list; address += 4.
      - Remaining list empty -> DONE; else stay in XFER with the next register. mem_req stays high, with no bubble between words.
  - DONE: done = 1 and busy = 1 for one cycle; mem_req = 0; -> IDLE.
- Ordering: registers always go in ascending index order at ascending addresses, regardless of up/pre.
- rf_en_n is all 1s in every state except an XFER cycle of a load with mem_ack high. Stores never drive enables low.
- mem_ack outside XFER is ignored.
- Total latency: 1 (SETUP) + sum of the per-word ack waits + 1 (DONE).
- CLR mid-transfer aborts immediately; no partial-state cleanup is needed beyond reset values.

Decomposition:
- Shared package:
  - State encoding constants (IDLE, SETUP, XFER, DONE).
  - Addressing-mode constants (IA, IB, DA, DB as {up, pre}).
  - Word-size constant of 4.
- Natural sub-module: prio_enc16, a combinational lowest-set-bit finder that outputs an index plus a valid flag. Popcount stays inline.

Test Plan:
- LDM IA, base 0x100, list 0x0005, mem_ack at the first XFER cycle:
  - Addresses 0x100 (reg_sel 0, rf_en_n = 0xFFFE), then 0x104 (reg_sel 2, rf_en_n = 0xFFFB).
  - done two cycles after the first ack; wb_addr 0x108.
- STM DB, base 0x200, list 0x8003:
  - mem_rw = 0 throughout; addresses 0x1F4 (R0), 0x1F8 (R1), 0x1FC (R15).
  - rf_en_n stays 0xFFFF; wb_addr 0x1F4.
- LDM IB vs DA, base 0x40, list 0x0010:
  - IB: single address 0x44, wb_addr 0x44.
  - DA: single address 0x40, wb_addr 0x3C.
- Empty list, start with list 0x0000:
  - SETUP then DONE, mem_req never asserted.
  - done in cycle 3 after start; wb_addr = base.
- Stall and ignore: mem_ack held low for 5 cycles mid-transfer, with start pulsed while busy:
  - mem_addr and reg_sel are stable; the second start has no effect.
  - Full list 0xFFFF IA from 0xFFFFFFF8 wraps to 0x00000000 at the third word; wb_addr 0x00000038.
- Reset abort: CLR pulsed during XFER of a load:
  - Immediately busy = 0, mem_req = 0, rf_en_n = 0xFFFF.
  - A subsequent start runs a fresh transfer correctly.
